// File: rtl/traffic_pkg.sv
// Shared phase encodings and count limits for the traffic-light phase sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_RED    = 2'b10
  } phase_e;

  localparam logic [3:0] CNT_START  = 4'd15;
  localparam logic [3:0] GREEN_END  = 4'd0;
  localparam logic [3:0] YELLOW_END = 4'd11;
  localparam logic [3:0] RED_END    = 4'd6;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Count-tick prescaler: wraps every TICK_DIV enabled cycles and issues a registered one-cycle tick.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // prescaler next value; frozen with no tick while run is low
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (run) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
        tick_d  = 1'b0;
      end
    end else begin
      presc_d = presc_q;
      tick_d  = 1'b0;
    end
  end

  // prescaler and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer: green/yellow/red phase code, decoder down-count and lamps.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       force_red,
  output logic [1:0] state,
  output logic [3:0] count,
  output logic       lamp_g,
  output logic       lamp_y,
  output logic       lamp_r,
  output logic       tick
);

  logic       tick_s;
  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       lamp_g_q, lamp_y_q, lamp_r_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick_s)
  );

  // phase/count next state; the illegal code recovers to red without waiting for a tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      PH_GREEN: begin
        if (tick_s) begin
          if (force_red || (count_q == GREEN_END)) begin
            state_d = PH_YELLOW;
            count_d = CNT_START;
          end else begin
            count_d = count_q - 4'd1;
          end
        end else begin
          count_d = count_q;
        end
      end
      PH_YELLOW: begin
        if (tick_s) begin
          if (count_q == YELLOW_END) begin
            state_d = PH_RED;
            count_d = CNT_START;
          end else begin
            count_d = count_q - 4'd1;
          end
        end else begin
          count_d = count_q;
        end
      end
      PH_RED: begin
        // force_red freezes the red countdown at its current value
        if (tick_s && !force_red) begin
          if (count_q == RED_END) begin
            state_d = PH_GREEN;
            count_d = CNT_START;
          end else begin
            count_d = count_q - 4'd1;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = PH_RED;
        count_d = CNT_START;
      end
    endcase
  end

  // phase, count and lamp registers; lamps decode the next phase so they stay aligned with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_GREEN;
      count_q  <= CNT_START;
      lamp_g_q <= 1'b1;
      lamp_y_q <= 1'b0;
      lamp_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lamp_g_q <= (state_d == PH_GREEN);
      lamp_y_q <= (state_d == PH_YELLOW);
      lamp_r_q <= (state_d == PH_RED);
    end
  end

  assign state  = state_q;
  assign count  = count_q;
  assign lamp_g = lamp_g_q;
  assign lamp_y = lamp_y_q;
  assign lamp_r = lamp_r_q;
  assign tick   = tick_s;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl with TICK_DIV=4.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       force_red;
  logic [1:0] state;
  logic [3:0] count;
  logic       lamp_g;
  logic       lamp_y;
  logic       lamp_r;
  logic       tick;

  int n_checks;
  int n_errors;
  int cyc;
  int c_a;
  int c_b;
  logic saw_tick;

  traffic_phase_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .force_red (force_red),
    .state     (state),
    .count     (count),
    .lamp_g    (lamp_g),
    .lamp_y    (lamp_y),
    .lamp_r    (lamp_r),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the negedge right after the next tick has been consumed.
  task automatic wait_step();
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("tick_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) wait_step();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    run       = 1'b0;
    force_red = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_count", {28'd0, count}, 32'd15);
    check_eq("rst_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b100);
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;

    // first tick lands four clocks after release
    repeat (3) @(negedge clk);
    check_eq("no_tick_clk3", {31'd0, tick}, 32'd0);
    @(negedge clk);
    check_eq("tick_clk4", {31'd0, tick}, 32'd1);
    check_eq("cnt_during_tick", {28'd0, count}, 32'd15);
    @(negedge clk);
    check_eq("green_cnt14", {28'd0, count}, 32'd14);
    for (int k = 13; k >= 0; k--) begin
      wait_step();
      check_eq("green_cnt", {28'd0, count}, k);
      check_eq("green_state", {30'd0, state}, 32'd0);
    end
    wait_step();
    c_a = cyc;
    check_eq("to_yellow_state", {30'd0, state}, 32'd1);
    check_eq("to_yellow_cnt", {28'd0, count}, 32'd15);
    check_eq("yellow_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b010);
    for (int k = 14; k >= 11; k--) begin
      wait_step();
      check_eq("yellow_cnt", {28'd0, count}, k);
    end
    wait_step();
    check_eq("to_red_state", {30'd0, state}, 32'd2);
    check_eq("to_red_cnt", {28'd0, count}, 32'd15);
    check_eq("red_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b001);
    for (int k = 14; k >= 6; k--) begin
      wait_step();
      check_eq("red_cnt", {28'd0, count}, k);
    end
    wait_step();
    check_eq("to_green_state", {30'd0, state}, 32'd0);
    check_eq("to_green_cnt", {28'd0, count}, 32'd15);
    check_eq("green_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b100);
    step_n(16);
    c_b = cyc;
    check_eq("period_state", {30'd0, state}, 32'd1);
    check_eq("period_clk", c_b - c_a, 32'd124);

    // walk to green count 9, then freeze with run=0
    step_n(5 + 10 + 6);
    check_eq("pre_freeze_state", {30'd0, state}, 32'd0);
    check_eq("pre_freeze_cnt", {28'd0, count}, 32'd9);
    run = 1'b0;
    saw_tick = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tick === 1'b1) saw_tick = 1'b1;
    end
    check_eq("freeze_no_tick", {31'd0, saw_tick}, 32'd0);
    check_eq("freeze_cnt", {28'd0, count}, 32'd9);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("resume_cnt_early", {28'd0, count}, 32'd9);
    @(negedge clk);
    check_eq("resume_cnt", {28'd0, count}, 32'd8);

    // force_red from green count 7
    wait_step();
    check_eq("force_pre_cnt", {28'd0, count}, 32'd7);
    force_red = 1'b1;
    wait_step();
    check_eq("force_yel_state", {30'd0, state}, 32'd1);
    check_eq("force_yel_cnt", {28'd0, count}, 32'd15);
    step_n(5);
    check_eq("force_red_state", {30'd0, state}, 32'd2);
    check_eq("force_red_cnt", {28'd0, count}, 32'd15);
    step_n(3);
    check_eq("force_hold_state", {30'd0, state}, 32'd2);
    check_eq("force_hold_cnt", {28'd0, count}, 32'd15);
    force_red = 1'b0;
    wait_step();
    check_eq("release_cnt", {28'd0, count}, 32'd14);
    step_n(5);
    check_eq("pre_rst_cnt", {28'd0, count}, 32'd9);

    // asynchronous reset mid-red
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", {30'd0, state}, 32'd0);
    check_eq("async_rst_cnt", {28'd0, count}, 32'd15);
    check_eq("async_rst_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b100);
    check_eq("async_rst_tick", {31'd0, tick}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_restart_no_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    check_eq("rst_restart_tick", {31'd0, tick}, 32'd1);
    @(negedge clk);

    // force_red on the tick that ends green naturally
    step_n(14);
    check_eq("edge_pre_cnt", {28'd0, count}, 32'd0);
    force_red = 1'b1;
    wait_step();
    check_eq("edge_state", {30'd0, state}, 32'd1);
    check_eq("edge_cnt", {28'd0, count}, 32'd15);
    force_red = 1'b0;
    wait_step();
    check_eq("edge_next_cnt", {28'd0, count}, 32'd14);

    // illegal phase code recovers to red on the next clock
    dut.state_q = 2'b11;
    @(negedge clk);
    check_eq("illegal_state", {30'd0, state}, 32'd2);
    check_eq("illegal_cnt", {28'd0, count}, 32'd15);
    check_eq("illegal_lamps", {29'd0, lamp_g, lamp_y, lamp_r}, 32'b001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Upstream sequencer for the traffic-light 7-segment decoder.
- Generates the 2-bit phase code (green/yellow/red) and the 4-bit down-count that the decoder maps to displayed seconds.
- Counts are encoded so the decoder shows 15..0 in green, 5..1 in yellow and A(10)..1 in red.
- Also drives the lamp outputs and a 1 Hz-style tick.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per count tick (minimum 2; benches use 4).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  1 = tick prescaler advances; 0 = freeze prescaler, count and phase
- force_red  input  1  request to drive and hold red (maintenance/emergency)
- state  output  2  phase code: 2'b00 green, 2'b01 yellow, 2'b10 red
- count  output  4  down-count fed to decoder "in"
- lamp_g  output  1  green lamp, high in green
- lamp_y  output  1  yellow lamp, high in yellow
- lamp_r  output  1  red lamp, high in red
- tick  output  1  one-clk pulse on each count step

Behaviour:
- One clock, reset is asynchronous and active-low: rst_n low immediately sets:
  - state=00 (green), count=15, lamp_g=1, lamp_y=0, lamp_r=0, tick=0
  - prescaler=0
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and wraps to 0.
  - tick is registered and high for exactly the cycle after the prescaler reaches TICK_DIV-1.
  - run=0 holds the prescaler value; no tick is issued.
- Count/phase updates happen only in the cycle tick is high. All outputs are registered; lamps are a registered decode of state, aligned with state.
- Phase end values (count value on the final tick of each phase): GREEN_END=0, YELLOW_END=11, RED_END=6.
- On tick:
  - If count != end value of the current phase: count <= count-1.
  - If count == end value: advance phase (green->yellow->red->green) and set count <= 15.
- Dwell per phase: green 16 ticks (15..0), yellow 5 ticks (15..11), red 10 ticks (15..6). Full cycle 31 ticks.
- count never wraps below 0 and never takes decoder-undefined values in yellow (1..10) or red (1..5); 0 is never produced outside green.
- force_red (sampled on tick only):
  - In green: move to yellow with count=15 on the next tick, regardless of count.
  - In yellow: the normal sequence continues to red.
  - In red: count holds at its current value and the phase does not exit while force_red=1.
  - After release, the countdown resumes from the held value on the next tick.
- If force_red is asserted on the same tick that green would naturally end (count=0): single transition to yellow, count=15 (no double step).
- Illegal state 2'b11: on the next clock edge (tick not required) go to red, count=15, lamp_r=1. This is the safe fallback.
- Reset mid-phase: immediate return to reset values; the prescaler restarts from 0.
- run deasserted mid-phase: all outputs hold; resumption continues the prescaler from the held value.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings PH_GREEN=2'b00, PH_YELLOW=2'b01, PH_RED=2'b10
  - CNT_START=4'd15, GREEN_END=4'd0, YELLOW_END=4'd11, RED_END=4'd6
- One sub-module, tick_gen: the prescaler with TICK_DIV, clk, rst_n, run in and tick out.
- Phase FSM and counter stay in traffic_phase_ctrl.

Test Plan:
- Reset then run=1, TICK_DIV=4:
  - first tick at clk 4 after release
  - state=00 with count stepping 15->0 over 16 ticks
  - then state=01, count=15, lamp_y=1
- Continue run:
  - yellow counts 15,14,13,12,11, then state=10, count=15
  - red counts 15..6, then state=00, count=15
  - full period = 31 ticks = 124 clk
- run=0 for 20 clk mid-green at count=9: no tick, count stays 9; after run=1, count=8 exactly one full prescaler period later.
- force_red=1 in green at count=7:
  - next tick gives state=01, count=15; red is reached after 5 ticks
  - held at count=15 while force_red=1
  - release gives 14 on the next tick
- force_red on the tick where green count=0: exactly one step to state=01, count=15.
- rst_n pulsed low mid-red at count=9:
  - outputs go to green, count=15 asynchronously, before the next clk edge
- Separately, force state=11 via backdoor: state=10, count=15 after one clk.
